// File: rtl/sync_split2_d_pkg.sv
// Shared types for the sync_split2_d two-way data split.
package sync_split2_d_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDrive,
    StWait,
    StFree
  } state_e;

  localparam int unsigned SyncDepth = 2;

endpackage

// File: rtl/sync_pulse_det.sv
// Two-flop synchronizer followed by a rising-edge detector; one-cycle pulse per input rise.
module sync_pulse_det
  import sync_split2_d_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic [SyncDepth-1:0] sync_q;
  logic                 last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncDepth-2:0], din};
      last_q <= sync_q[SyncDepth-1];
    end
  end

  assign pulse = sync_q[SyncDepth-1] & ~last_q;

endmodule

// File: rtl/sync_split2_d.sv
// Two-way drive/free data split: captures one word, routes it to the port picked by i_data[SEL_BIT].
// Optional input synchronizers are enabled with `define SPLIT2_IN_SYNC_EN.
module sync_split2_d
  import sync_split2_d_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned SEL_BIT    = 0,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_drive,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_free,
  output logic                  o_drive0,
  output logic                  o_drive1,
  output logic [DATA_WIDTH-1:0] o_data0,
  output logic [DATA_WIDTH-1:0] o_data1,
  input  logic                  i_free0,
  input  logic                  i_free1,
  output logic                  o_busy,
  output logic                  o_ovf,
  output logic [CNT_WIDTH-1:0]  o_cnt0,
  output logic [CNT_WIDTH-1:0]  o_cnt1
);

  logic drive_ev;
  logic free0_ev;
  logic free1_ev;

`ifdef SPLIT2_IN_SYNC_EN
  sync_pulse_det u_sync_drive (
    .clk  (clk),
    .rst  (rst),
    .din  (i_drive),
    .pulse(drive_ev)
  );

  sync_pulse_det u_sync_free0 (
    .clk  (clk),
    .rst  (rst),
    .din  (i_free0),
    .pulse(free0_ev)
  );

  sync_pulse_det u_sync_free1 (
    .clk  (clk),
    .rst  (rst),
    .din  (i_free1),
    .pulse(free1_ev)
  );
`else
  assign drive_ev = i_drive;
  assign free0_ev = i_free0;
  assign free1_ev = i_free1;
`endif

  state_e                state;
  logic [DATA_WIDTH-1:0] cap;
  logic                  sel;
  logic                  free_sel;

  // Only the selected port's free can end the wait.
  assign free_sel = sel ? free1_ev : free0_ev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      cap      <= '0;
      sel      <= 1'b0;
      o_data0  <= '0;
      o_data1  <= '0;
      o_drive0 <= 1'b0;
      o_drive1 <= 1'b0;
      o_free   <= 1'b0;
      o_busy   <= 1'b0;
      o_ovf    <= 1'b0;
      o_cnt0   <= '0;
      o_cnt1   <= '0;
    end else begin
      o_drive0 <= 1'b0;
      o_drive1 <= 1'b0;
      o_free   <= 1'b0;
      // o_busy tracks LOAD/DRIVE/WAIT, so it doubles as the overrun qualifier.
      if (drive_ev && o_busy) begin
        o_ovf <= 1'b1;
      end
      case (state)
        StIdle: begin
          if (drive_ev) begin
            cap    <= i_data;
            sel    <= i_data[SEL_BIT];
            o_busy <= 1'b1;
            state  <= StLoad;
          end
        end
        StLoad: begin
          if (sel) begin
            o_data1 <= cap;
          end else begin
            o_data0 <= cap;
          end
          state <= StDrive;
        end
        StDrive: begin
          if (sel) begin
            o_drive1 <= 1'b1;
          end else begin
            o_drive0 <= 1'b1;
          end
          state <= StWait;
        end
        StWait: begin
          if (free_sel) begin
            o_busy <= 1'b0;
            state  <= StFree;
          end
        end
        StFree: begin
          o_free <= 1'b1;
          if (sel) begin
            o_cnt1 <= o_cnt1 + CNT_WIDTH'(1);
          end else begin
            o_cnt0 <= o_cnt0 + CNT_WIDTH'(1);
          end
          if (drive_ev) begin
            cap    <= i_data;
            sel    <= i_data[SEL_BIT];
            o_busy <= 1'b1;
            state  <= StLoad;
          end else begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_split2_d.sv
// Bench for sync_split2_d: vector table, directed corner sequences, random run against a timeline model.
module tb_sync_split2_d;

  localparam int unsigned DW = 128;
  localparam int unsigned CW = 2;

  localparam logic [DW-1:0] DatA = 128'hA5A4;
  localparam logic [DW-1:0] DatB = 128'h1234_5678_0000_00F0;
  localparam logic [DW-1:0] DatC = 128'h3;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_drive;
  logic [DW-1:0] i_data;
  logic          i_free0;
  logic          i_free1;
  logic          o_free;
  logic          o_drive0;
  logic          o_drive1;
  logic [DW-1:0] o_data0;
  logic [DW-1:0] o_data1;
  logic          o_busy;
  logic          o_ovf;
  logic [CW-1:0] o_cnt0;
  logic [CW-1:0] o_cnt1;

  sync_split2_d #(
    .DATA_WIDTH(DW),
    .SEL_BIT   (0),
    .CNT_WIDTH (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_drive (i_drive),
    .i_data  (i_data),
    .o_free  (o_free),
    .o_drive0(o_drive0),
    .o_drive1(o_drive1),
    .o_data0 (o_data0),
    .o_data1 (o_data1),
    .i_free0 (i_free0),
    .i_free1 (i_free1),
    .o_busy  (o_busy),
    .o_ovf   (o_ovf),
    .o_cnt0  (o_cnt0),
    .o_cnt1  (o_cnt1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Timeline model: a transfer is counted in edges since acceptance.
  logic          m_busy, m_ovf, m_free, m_drv0, m_drv1, m_pend, m_sel;
  logic [DW-1:0] m_cap, m_data0, m_data1;
  logic [CW-1:0] m_cnt0, m_cnt1;
  int            m_age;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic d, input logic [DW-1:0] dat,
                            input logic a0, input logic a1);
    m_drv0 = 1'b0;
    m_drv1 = 1'b0;
    m_free = 1'b0;
    if (r) begin
      m_busy  = 1'b0;
      m_ovf   = 1'b0;
      m_pend  = 1'b0;
      m_sel   = 1'b0;
      m_cap   = '0;
      m_data0 = '0;
      m_data1 = '0;
      m_cnt0  = '0;
      m_cnt1  = '0;
      m_age   = 0;
    end else begin
      if (m_pend) begin
        m_pend = 1'b0;
        m_free = 1'b1;
        if (m_sel) m_cnt1 = m_cnt1 + 1'b1;
        else m_cnt0 = m_cnt0 + 1'b1;
      end
      if (m_busy) begin
        m_age++;
        if (d) m_ovf = 1'b1;
        if (m_age == 1) begin
          if (m_sel) m_data1 = m_cap;
          else m_data0 = m_cap;
        end
        if (m_age == 2) begin
          if (m_sel) m_drv1 = 1'b1;
          else m_drv0 = 1'b1;
        end
        if (m_age >= 3 && (m_sel ? a1 : a0)) begin
          m_busy = 1'b0;
          m_pend = 1'b1;
        end
      end else if (d) begin
        m_busy = 1'b1;
        m_age  = 0;
        m_cap  = dat;
        m_sel  = dat[0];
      end
    end
  endtask

  task automatic check_model();
    chk("model_drive0", o_drive0, m_drv0);
    chk("model_drive1", o_drive1, m_drv1);
    chk("model_free", o_free, m_free);
    chk("model_busy", o_busy, m_busy);
    chk("model_ovf", o_ovf, m_ovf);
    chk("model_cnt0", o_cnt0, m_cnt0);
    chk("model_cnt1", o_cnt1, m_cnt1);
    chk("model_data0", o_data0, m_data0);
    chk("model_data1", o_data1, m_data1);
  endtask

  // Apply inputs, clock one edge, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic d, input logic [DW-1:0] dat,
                      input logic a0, input logic a1);
    rst     = r;
    i_drive = d;
    i_data  = dat;
    i_free0 = a0;
    i_free1 = a1;
    @(posedge clk);
    model_edge(r, d, dat, a0, a1);
    #1;
    check_model();
  endtask

  typedef struct {
    logic          r;
    logic          d;
    logic [DW-1:0] dat;
    logic          f0;
    logic          f1;
    logic          e_d0;
    logic          e_d1;
    logic          e_fr;
    logic          e_busy;
    logic          e_ovf;
    logic [CW-1:0] e_c0;
    logic [CW-1:0] e_c1;
    logic [DW-1:0] e_data0;
    logic [DW-1:0] e_data1;
  } vec_t;

  vec_t vecs[16];
  logic [CW-1:0] wrap_exp[5];

  initial begin
    // r d dat f0 f1 | drv0 drv1 free busy ovf cnt0 cnt1 data0 data1
    vecs[0]  = '{1'b1, 1'b0, '0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, '0,   '0};
    vecs[1]  = '{1'b0, 1'b1, DatA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, '0,   '0};
    vecs[2]  = '{1'b0, 1'b0, '0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, DatA, '0};
    vecs[3]  = '{1'b0, 1'b0, '0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, DatA, '0};
    vecs[4]  = '{1'b0, 1'b0, '0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, DatA, '0};
    vecs[5]  = '{1'b0, 1'b0, '0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, DatA, '0};
    vecs[6]  = '{1'b0, 1'b0, '0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, DatA, '0};
    vecs[7]  = '{1'b0, 1'b1, DatC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, DatA, '0};
    vecs[8]  = '{1'b0, 1'b0, '0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, DatA, DatC};
    vecs[9]  = '{1'b0, 1'b1, DatA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 2'd0, DatA, DatC};
    vecs[10] = '{1'b0, 1'b0, '0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, DatA, DatC};
    vecs[11] = '{1'b0, 1'b1, DatB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 2'd1, DatA, DatC};
    vecs[12] = '{1'b0, 1'b0, '0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 2'd1, DatB, DatC};
    vecs[13] = '{1'b0, 1'b0, '0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 2'd1, DatB, DatC};
    vecs[14] = '{1'b0, 1'b0, '0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1, DatB, DatC};
    vecs[15] = '{1'b0, 1'b0, '0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 2'd1, DatB, DatC};
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].r, vecs[i].d, vecs[i].dat, vecs[i].f0, vecs[i].f1);
      chk($sformatf("vec%0d_drive0", i), o_drive0, vecs[i].e_d0);
      chk($sformatf("vec%0d_drive1", i), o_drive1, vecs[i].e_d1);
      chk($sformatf("vec%0d_free", i), o_free, vecs[i].e_fr);
      chk($sformatf("vec%0d_busy", i), o_busy, vecs[i].e_busy);
      chk($sformatf("vec%0d_ovf", i), o_ovf, vecs[i].e_ovf);
      chk($sformatf("vec%0d_cnt0", i), o_cnt0, vecs[i].e_c0);
      chk($sformatf("vec%0d_cnt1", i), o_cnt1, vecs[i].e_c1);
      chk($sformatf("vec%0d_data0", i), o_data0, vecs[i].e_data0);
      chk($sformatf("vec%0d_data1", i), o_data1, vecs[i].e_data1);
    end

    // Wrong-port free is ignored, then reset abandons the transfer without a free.
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, DatA, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("wrongport_busy", o_busy, 1'b1);
    step(1'b0, 1'b1, DatB, 1'b0, 1'b1);
    chk("wrongport_ovf", o_ovf, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_ovf", o_ovf, 1'b0);
    chk("rst_data0", o_data0, '0);
    chk("rst_free", o_free, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("rst_late_free", o_free, 1'b0);
    chk("rst_late_cnt0", o_cnt0, 2'd0);

    // Counter wrap on port 0 with zero-wait free.
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, DatA, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      chk($sformatf("wrap%0d_free", k), o_free, 1'b1);
      chk($sformatf("wrap%0d_cnt0", k), o_cnt0, wrap_exp[k]);
    end

    // Back-to-back: drive in the FREE cycle is accepted with no overrun.
    step(1'b0, 1'b1, DatC, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("b2b_first_drive1", o_drive1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b1, DatB, 1'b0, 1'b0);
    chk("b2b_free", o_free, 1'b1);
    chk("b2b_busy", o_busy, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("b2b_data0", o_data0, DatB);
    chk("b2b_data1_kept", o_data1, DatC);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("b2b_drive0", o_drive0, 1'b1);
    chk("b2b_ovf", o_ovf, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      logic [DW-1:0] dat;
      dat = {$urandom, $urandom, $urandom, $urandom};
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, dat,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_split2_d.md
# sync_split2_d

Clocked two-way data split, the receiving end of the drive/free data channel that the two-input mutex merge produces. It accepts one drive event with data, holds the data persistently, and routes the event to exactly one of two downstream ports chosen by a route bit in the data. It waits for that port's free, then returns free upstream. It sits after a merge stage in the control chain, wherever a merged stream must be steered back out to two consumers.

## Interface
- `DATA_WIDTH`, 128: width of the data word.
- `SEL_BIT`, 0: index of the route bit inside `i_data`. 0 selects port 0, 1 selects port 1. Must be less than `DATA_WIDTH`.
- `CNT_WIDTH`, 16: width of each per-port transfer counter.
- `clk`  in  1  the single clock.
- `rst`  in  1  synchronous, active-high reset.
- `i_drive`  in  1  upstream drive event. One-cycle pulse, or a raw asynchronous pulse when `SPLIT2_IN_SYNC_EN` is set.
- `i_data`  in  `DATA_WIDTH`  upstream data. Valid in the cycle `i_drive` is sampled.
- `o_free`  out  1  one-cycle pulse returned upstream when the transfer completes.
- `o_drive0` / `o_drive1`  out  1  one-cycle drive pulse to port 0 or port 1.
- `o_data0` / `o_data1`  out  `DATA_WIDTH`  registered data for each port, held until that port's next capture.
- `i_free0` / `i_free1`  in  1  downstream free pulse from each port.
- `o_busy`  out  1  high from acceptance until `o_free` is issued.
- `o_ovf`  out  1  sticky flag: a drive was dropped because the block was busy.
- `o_cnt0` / `o_cnt1`  out  `CNT_WIDTH`  number of completed transfers per port. Wraps modulo 2^`CNT_WIDTH`.

## Operation
- States:
  - IDLE: waiting for a drive.
  - LOAD: data captured.
  - DRIVE: drive pulse issued.
  - WAIT: waiting for the selected port's free.
  - FREE: free returned upstream.
- IDLE, `i_drive` seen: latch `i_data` into a capture register and latch `sel = i_data[SEL_BIT]`. Go to LOAD.
- LOAD: copy the capture register to `o_data<sel>`. The other port's data register is unchanged. Go to DRIVE.
- DRIVE: `o_drive<sel>` = 1 for this cycle only. Go to WAIT.
- WAIT: wait for `i_free<sel>`. Then increment `o_cnt<sel>` and go to FREE.
  - `i_free` from the non-selected port is ignored.
  - There is no timeout; WAIT is held indefinitely.
- FREE: `o_free` = 1 for this cycle only.
  - If `i_drive` is seen in this same cycle, it is accepted: capture as in IDLE and go to LOAD.
  - Otherwise go to IDLE.
- A drive seen in LOAD, DRIVE or WAIT is dropped: no capture, no routing, and `o_ovf` is set. `o_ovf` is cleared only by `rst`.
- `o_busy` = 1 in LOAD, DRIVE and WAIT. It is 0 in IDLE and FREE.
- Counter at all ones plus one completion wraps to 0. No flag is raised.

## Timing
- Reset value of every output is 0: drives, `o_free`, `o_busy`, `o_ovf`, both counters and both data registers. State is IDLE.
- `rst` mid-transfer: return to IDLE on the next edge.
  - No `o_free` is issued for the abandoned transfer.
  - A pending downstream free arriving after reset is ignored.
- `i_drive` sampled at edge N:
  - `o_data<sel>` valid from edge N+1.
  - `o_drive<sel>` high between edges N+2 and N+3.
  - Data is therefore stable at least one full cycle before the drive pulse.
- `i_free<sel>` sampled at edge M (in WAIT): `o_free` high between edges M+1 and M+2; `o_cnt<sel>` updated at edge M+1.
- Minimum cycle-to-cycle throughput is 4 cycles per transfer, given zero-wait free and back-to-back acceptance in FREE.
- Simultaneous `i_free0` and `i_free1` in WAIT: only `i_free<sel>` counts.

## Configuration
- `SPLIT2_IN_SYNC_EN` defined:
  - `i_drive`, `i_free0` and `i_free1` each pass through a 2-flop synchronizer followed by a rising-edge detector before use.
  - Input pulses must be high for at least 2 `clk` periods.
  - `i_data` must be stable from the `i_drive` rising edge until `o_busy` rises.
  - All input-referred latencies above grow by 2 cycles.
- `SPLIT2_IN_SYNC_EN` undefined:
  - Inputs are used directly as one-cycle synchronous pulses.
  - A level held for several cycles counts as one event per cycle.

## Structure
- Shared package:
  - state enumeration (IDLE, LOAD, DRIVE, WAIT, FREE);
  - localparam for synchronizer depth (2).
- One natural sub-module: `sync_pulse_det`, the 2-flop synchronizer plus rising-edge detector, instantiated three times, only under `SPLIT2_IN_SYNC_EN`.

## Test plan
- Route to port 0: reset, then `i_drive` with `i_data=128'h...A5A4` (bit0=0) -> `o_data0=...A5A4` at N+1; `o_drive0` pulse at N+2; `o_drive1` stays 0. Then `i_free0` -> `o_free` pulse next cycle; `o_cnt0=1`.
- Route to port 1: `i_data=128'h3` (bit0=1) -> `o_drive1` pulse. `o_data0` keeps the prior value.
- Overrun: a second `i_drive` while in WAIT -> no new drive; `o_ovf=1`, held sticky until `rst`. The transfer in flight completes normally.
- Back-to-back: `i_drive` in the FREE cycle -> accepted; next `o_drive` 3 cycles later; `o_ovf` stays 0.
- Wrong-port free and reset mid-flight:
  - `i_free1` while port 0 is selected -> ignored; still waiting.
  - Then `rst` -> all outputs 0; no `o_free`.
- Counter wrap: `CNT_WIDTH=2`, 5 port-0 transfers -> `o_cnt0` reads 1,2,3,0,1.
